// File: rtl/output_bcd_converter_if.sv
// Bus-side bundle for the output register / BCD converter: OI strobe and
// bus value in, converted digits and display write-enable out.
interface output_bcd_converter_if;
  logic [7:0] i_bus;
  logic       i_load;
  logic       i_signed;
  logic       o_busy;
  logic       o_valid;
  logic [7:0] o_value;
  logic       o_sign;
  logic [3:0] o_hundreds;
  logic [3:0] o_tens;
  logic [3:0] o_ones;

  modport master (
    output i_bus, i_load, i_signed,
    input  o_busy, o_valid, o_value, o_sign, o_hundreds, o_tens, o_ones
  );

  modport slave (
    input  i_bus, i_load, i_signed,
    output o_busy, o_valid, o_value, o_sign, o_hundreds, o_tens, o_ones
  );
endinterface

// File: rtl/output_bcd_converter.sv
// Output register stage: captures the bus on OI, converts to three BCD digits
// with one double-dabble step per clock, and pulses o_valid for the display.
module output_bcd_converter #(
  parameter bit LEAD_ZERO_BLANK = 1'b1
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  output_bcd_converter_if.slave   bus_if
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  raw_q, raw_d;
  logic [7:0]  mag_q, mag_d;
  logic        neg_q, neg_d;
  logic [11:0] bcd_q, bcd_d;

  logic        pend_q, pend_d;
  logic [7:0]  pbus_q, pbus_d;
  logic        psgn_q, psgn_d;

  logic        busy_q, busy_d;
  logic        valid_q, valid_d;
  logic [7:0]  value_q, value_d;
  logic        sign_q, sign_d;
  logic [3:0]  hund_q, hund_d;
  logic [3:0]  tens_q, tens_d;
  logic [3:0]  ones_q, ones_d;

  logic        capture;
  logic [7:0]  cap_bus;
  logic        cap_sgn;
  logic [7:0]  neg_mag;
  logic [11:0] bcd_adj;

  function automatic logic [3:0] dabble_adj(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  // Capture source: a load on the DONE edge beats the pending slot.
  always_comb begin
    capture = 1'b0;
    cap_bus = bus_if.i_bus;
    cap_sgn = bus_if.i_signed;
    case (state_q)
      IDLE: capture = bus_if.i_load;
      DONE: begin
        if (bus_if.i_load) begin
          capture = 1'b1;
        end else if (pend_q) begin
          capture = 1'b1;
          cap_bus = pbus_q;
          cap_sgn = psgn_q;
        end
      end
      default: capture = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus_if.i_load) state_d = SHIFT;
      SHIFT:   if (cnt_q == 3'd7) state_d = DONE;
      DONE:    state_d = capture ? SHIFT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Conversion datapath and pending slot.
  // 8-bit negate suffices: 0x80 negates to 0x80, read unsigned as 128.
  assign neg_mag = ~cap_bus + 8'd1;
  assign bcd_adj = {dabble_adj(bcd_q[11:8]), dabble_adj(bcd_q[7:4]),
                    dabble_adj(bcd_q[3:0])};

  always_comb begin
    raw_d  = raw_q;
    mag_d  = mag_q;
    neg_d  = neg_q;
    bcd_d  = bcd_q;
    cnt_d  = cnt_q;
    pend_d = pend_q;
    pbus_d = pbus_q;
    psgn_d = psgn_q;

    if (capture) begin
      raw_d = cap_bus;
      neg_d = cap_sgn & cap_bus[7];
      mag_d = (cap_sgn & cap_bus[7]) ? neg_mag : cap_bus;
      bcd_d = '0;
      cnt_d = '0;
    end else if (state_q == SHIFT) begin
      {bcd_d, mag_d} = {bcd_adj, mag_q} << 1;
      cnt_d          = cnt_q + 3'd1;
    end

    if (state_q == SHIFT && bus_if.i_load) begin
      pend_d = 1'b1;
      pbus_d = bus_if.i_bus;
      psgn_d = bus_if.i_signed;
    end else if (state_q == DONE) begin
      pend_d = 1'b0;
    end
  end

  // Output logic: results only move on the DONE edge.
  always_comb begin
    busy_d  = (state_d != IDLE);
    valid_d = (state_q == DONE);
    value_d = value_q;
    sign_d  = sign_q;
    hund_d  = hund_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    if (state_q == DONE) begin
      value_d = raw_q;
      sign_d  = neg_q;
      ones_d  = bcd_q[3:0];
      hund_d  = (LEAD_ZERO_BLANK && bcd_q[11:8] == 4'd0) ? 4'hF : bcd_q[11:8];
      tens_d  = (LEAD_ZERO_BLANK && bcd_q[11:4] == 8'd0) ? 4'hF : bcd_q[7:4];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q   <= '0;
      raw_q   <= '0;
      mag_q   <= '0;
      neg_q   <= 1'b0;
      bcd_q   <= '0;
      pend_q  <= 1'b0;
      pbus_q  <= '0;
      psgn_q  <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      value_q <= '0;
      sign_q  <= 1'b0;
      hund_q  <= '0;
      tens_q  <= '0;
      ones_q  <= '0;
    end else begin
      cnt_q   <= cnt_d;
      raw_q   <= raw_d;
      mag_q   <= mag_d;
      neg_q   <= neg_d;
      bcd_q   <= bcd_d;
      pend_q  <= pend_d;
      pbus_q  <= pbus_d;
      psgn_q  <= psgn_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      value_q <= value_d;
      sign_q  <= sign_d;
      hund_q  <= hund_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
    end
  end

  assign bus_if.o_busy     = busy_q;
  assign bus_if.o_valid    = valid_q;
  assign bus_if.o_value    = value_q;
  assign bus_if.o_sign     = sign_q;
  assign bus_if.o_hundreds = hund_q;
  assign bus_if.o_tens     = tens_q;
  assign bus_if.o_ones     = ones_q;

endmodule

// File: tb/tb_output_bcd_converter.sv
// Randomized and directed bench for output_bcd_converter, blanked and
// unblanked instances driven in lockstep against an edge-count model.
module tb_output_bcd_converter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  output_bcd_converter_if b0 ();
  output_bcd_converter_if b1 ();

  output_bcd_converter #(.LEAD_ZERO_BLANK(1'b1)) dut0 (
    .i_clk(clk), .i_rst(rst), .bus_if(b0.slave));
  output_bcd_converter #(.LEAD_ZERO_BLANK(1'b0)) dut1 (
    .i_clk(clk), .i_rst(rst), .bus_if(b1.slave));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Model: a conversion started at edge S presents at edge S+9.
  int         edge_n = 0;
  bit         act;
  int         start_e;
  logic [7:0] cur_v;
  bit         cur_s;
  bit         pv;
  logic [7:0] pval;
  bit         ps;
  logic       e_valid, e_busy, e_sign;
  logic [7:0] e_value;
  logic [3:0] e_h1, e_t1, e_h0, e_t0, e_o;

  task automatic model_clear();
    act = 0; pv = 0; start_e = 0; cur_v = 0; cur_s = 0; pval = 0; ps = 0;
    e_valid = 0; e_busy = 0; e_sign = 0; e_value = 0;
    e_h1 = 0; e_t1 = 0; e_h0 = 0; e_t0 = 0; e_o = 0;
  endtask

  task automatic present(input logic [7:0] v, input bit s);
    int mag, h, t;
    mag = (s && v[7]) ? 256 - int'(v) : int'(v);
    h = mag / 100;
    t = (mag / 10) % 10;
    e_value = v;
    e_sign  = s && v[7];
    e_o     = 4'(mag % 10);
    e_h0    = 4'(h);
    e_t0    = 4'(t);
    e_h1    = (h == 0) ? 4'hF : 4'(h);
    e_t1    = (h == 0 && t == 0) ? 4'hF : 4'(t);
    e_valid = 1;
  endtask

  task automatic model_edge(input bit r, input bit ld, input logic [7:0] v, input bit s);
    if (r) begin
      model_clear();
      return;
    end
    e_valid = 0;
    if (act && edge_n == start_e + 9) begin
      present(cur_v, cur_s);
      if (ld) begin
        start_e = edge_n; cur_v = v; cur_s = s;
      end else if (pv) begin
        start_e = edge_n; cur_v = pval; cur_s = ps;
      end else begin
        act = 0;
      end
      pv = 0;
    end else if (act) begin
      if (ld) begin pv = 1; pval = v; ps = s; end
    end else if (ld) begin
      act = 1; start_e = edge_n; cur_v = v; cur_s = s;
    end
    e_busy = act;
  endtask

  task automatic step(input bit r, input bit ld, input logic [7:0] v, input bit s);
    rst = r;
    b0.i_load = ld; b0.i_bus = v; b0.i_signed = s;
    b1.i_load = ld; b1.i_bus = v; b1.i_signed = s;
    @(posedge clk);
    model_edge(r, ld, v, s);
    edge_n++;
    #1;
    chk("valid",  {31'd0, b0.o_valid}, {31'd0, e_valid});
    chk("busy",   {31'd0, b0.o_busy},  {31'd0, e_busy});
    chk("value",  {24'd0, b0.o_value}, {24'd0, e_value});
    chk("sign",   {31'd0, b0.o_sign},  {31'd0, e_sign});
    chk("hund_b", {28'd0, b0.o_hundreds}, {28'd0, e_h1});
    chk("tens_b", {28'd0, b0.o_tens},  {28'd0, e_t1});
    chk("ones_b", {28'd0, b0.o_ones},  {28'd0, e_o});
    chk("valid_nb", {31'd0, b1.o_valid}, {31'd0, e_valid});
    chk("busy_nb",  {31'd0, b1.o_busy},  {31'd0, e_busy});
    chk("hund_nb",  {28'd0, b1.o_hundreds}, {28'd0, e_h0});
    chk("tens_nb",  {28'd0, b1.o_tens},  {28'd0, e_t0});
    chk("ones_nb",  {28'd0, b1.o_ones},  {28'd0, e_o});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, $urandom, $urandom_range(0, 1));
  endtask

  task automatic load(input logic [7:0] v, input bit s);
    step(0, 1, v, s);
  endtask

  initial begin
    model_clear();
    step(1, 0, 8'h00, 0);
    step(1, 1, 8'h55, 1);
    idle(2);

    // Single conversions: max unsigned, signed -1, 0xFF unsigned, -128, zero, 7
    load(8'hFF, 0); idle(11);
    load(8'hFF, 1); idle(11);
    load(8'hFF, 0); idle(11);
    load(8'h80, 1); idle(11);
    load(8'h00, 0); idle(11);
    load(8'h07, 0); idle(11);

    // Loads while busy: only the latest pending value survives
    load(8'h2A, 0); idle(2); load(8'h11, 0); idle(1); load(8'h07, 0); idle(20);

    // Reset mid-conversion, then a fresh load
    load(8'h63, 0); idle(3); step(1, 0, 8'h00, 0); idle(1); load(8'h05, 0); idle(12);

    // Load exactly on the DONE edge restarts back-to-back
    load(8'h10, 0); idle(8); load(8'hC8, 0); idle(12);

    // Load on DONE edge overrides a pending value
    load(8'h21, 1); idle(3); load(8'h99, 0); idle(4); load(8'hF6, 1); idle(20);

    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 149) == 0, $urandom_range(0, 3) == 0,
           8'($urandom), $urandom_range(0, 1) == 1);
    end
    idle(25);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/output_bcd_converter.md
Name: output_bcd_converter

Overview:
- Output-register stage directly upstream of the 3-digit seven-segment display driver.
- Captures the CPU bus value when the output-in (OI) control strobe fires and converts it to three BCD digits with sequential double-dabble, one shift per clock.
- Supports unsigned and two's-complement display modes.
- Emits a one-cycle o_valid pulse that drives the display's write enable.

Parameters:
- LEAD_ZERO_BLANK, 1: when 1, leading zero digits are output as 4'hF (blank code); when 0, digits are output as-is.

Ports:
- i_clk  input  1  system clock
- i_rst  input  1  synchronous active-high reset
- i_bus  input  8  CPU bus value
- i_load  input  1  OI strobe; capture i_bus on this edge
- i_signed  input  1  1 = interpret i_bus as two's complement; sampled with i_load
- o_busy  output  1  high while a conversion is in progress (state != IDLE)
- o_valid  output  1  one-cycle pulse when new digits/value are presented
- o_value  output  8  raw captured bus value of the presented result
- o_sign  output  1  1 = presented result is negative
- o_hundreds  output  4  BCD hundreds digit, or 4'hF when blanked
- o_tens  output  4  BCD tens digit, or 4'hF when blanked
- o_ones  output  4  BCD ones digit, never blanked

Behaviour:
- Reset (synchronous, i_rst high at an edge):
  - state=IDLE; pending flag cleared.
  - All outputs 0, including o_busy and o_valid.
  - Any conversion in flight is abandoned and no o_valid is produced.
- States: IDLE, SHIFT, DONE.
- Capture (edge 0: i_load=1 in IDLE):
  - Latch raw = i_bus.
  - If i_signed and i_bus[7]: mag = (~i_bus + 1) as a 9-bit quantity, so 0x80 gives 128; neg=1.
  - Otherwise mag = i_bus; neg=0.
  - Clear the 12-bit BCD accumulator; iteration count=0; go to SHIFT.
- SHIFT (edges 1..8, one iteration per edge):
  - For each BCD nibble >= 5, add 3.
  - Then shift {bcd, mag} left by 1.
  - After the 8th iteration, go to DONE.
- DONE (edge 9):
  - Register o_value=raw, o_sign=neg, and the digits (with blanking applied).
  - Assert o_valid=1 for exactly one cycle; it returns to 0 at edge 10 unless another DONE occurs.
- Latency: i_load sampled at edge N gives o_valid high in the cycle following edge N+9.
- Blanking (LEAD_ZERO_BLANK=1):
  - hundreds==0 → o_hundreds=F.
  - hundreds==0 && tens==0 → o_tens=F.
  - o_ones is always numeric.
- Outputs hold their last result until the next DONE; they never change mid-conversion.
- o_busy is registered and equals (next state != IDLE); it falls at the same edge o_valid rises, unless a pending load restarts conversion.
- Load while busy (i_load in SHIFT or DONE):
  - Store i_bus/i_signed into a one-deep pending slot and set the pending flag.
  - A later load overwrites the slot; only the latest value is kept.
- At the DONE edge:
  - If i_load=1 on that same edge, capture i_bus directly (it takes priority) and clear pending.
  - Else if pending, capture from the slot and clear pending.
  - In either case go to SHIFT (o_busy stays 1).
  - Otherwise go to IDLE.
- i_load while IDLE always starts immediately; pending is never used from IDLE.
- Arithmetic: 8-bit magnitude maximum is 255, and signed magnitude maximum is 128, so three digits always suffice and there is no overflow.

Test Plan:
- Unsigned 8'd255 load → o_valid pulse at edge+9; o_hundreds=2, o_tens=5, o_ones=5, o_sign=0, o_value=8'hFF.
- Signed 8'hFF → o_sign=1, o_hundreds=F, o_tens=F, o_ones=1; same 0xFF unsigned → 2,5,5.
- Signed 8'h80 → o_sign=1, digits 1,2,8; unsigned 8'h00 → F,F,0; with LEAD_ZERO_BLANK=0, 8'h07 → 0,0,7.
- Load 8'h2A at edge 0, 8'h11 at edge 3, 8'h07 at edge 5 (all unsigned):
  - First o_valid at edge 9 shows F,4,2.
  - o_busy stays 1.
  - Second o_valid at edge 18 shows F,F,7; 8'h11 is never presented.
- Load 8'h63 at edge 0, i_rst at edge 4 → all outputs 0 after edge 4, no o_valid ever; new load 8'h05 at edge 6 → o_valid at edge 15 with F,F,5.
- Load 8'h10 at edge 0 and i_load with 8'hC8 exactly at edge 9 → first result F,1,6 presented; o_busy held 1; second o_valid at edge 18 shows 2,0,0.
